// File: rtl/dma_stream_fifo.sv
// Per-stream byte-granular circular FIFO. It accepts 1/2/4-byte pushes and serves 1/2/4-byte pops.
// Optional threshold output is enabled by defining DMA_FIFO_THRESH_EN.
module dma_stream_fifo #(
   parameter int fifo_size = 5
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_clear,
   input  logic                 i_wr_en,
   input  logic [1:0]           i_wr_size,
   input  logic [31:0]          i_wr_data,
   output logic                 o_wr_ready,
   input  logic                 i_rd_en,
   input  logic [1:0]           i_rd_size,
   output logic [31:0]          o_rd_data,
   output logic                 o_rd_valid,
   output logic [fifo_size:0]   o_left_bytes,
   output logic                 o_empty,
   output logic                 o_full,
`ifdef DMA_FIFO_THRESH_EN
   input  logic [1:0]           i_fth,
   output logic                 o_fth_hit,
`endif
   output logic                 o_err
);
   localparam int DEPTH = 1 << fifo_size;
   localparam int PW    = fifo_size;
   localparam int CW    = fifo_size + 1;

   logic [7:0]    mem_q [DEPTH];
   logic [7:0]    mem_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d, free_bytes;
   logic          err_q, err_d;
   logic [2:0]    nwr, nrd;
   logic          wr_fire, rd_fire;

   // Illegal encoding maps to zero bytes, so it can never satisfy ready/valid.
   function automatic logic [2:0] size_bytes(input logic [1:0] s);
      case (s)
         2'd0:    return 3'd1;
         2'd1:    return 3'd2;
         2'd2:    return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

   always_comb begin
      nwr        = size_bytes(i_wr_size);
      nrd        = size_bytes(i_rd_size);
      free_bytes = CW'(DEPTH) - count_q;
      o_wr_ready = (nwr != 3'd0) && (free_bytes >= CW'(nwr));
      o_rd_valid = (nrd != 3'd0) && (count_q >= CW'(nrd));
      wr_fire    = i_wr_en && o_wr_ready;
      rd_fire    = i_rd_en && o_rd_valid;

      o_rd_data = '0;
      if (o_rd_valid) begin
         for (int k = 0; k < 4; k++) begin
            if (k < int'(nrd)) o_rd_data[8*k +: 8] = mem_q[PW'(rd_ptr_q + PW'(k))];
         end
      end

      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = err_q;
      if (i_clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         err_d    = 1'b0;
      end else begin
         if (wr_fire) begin
            for (int k = 0; k < 4; k++) begin
               if (k < int'(nwr)) mem_d[PW'(wr_ptr_q + PW'(k))] = i_wr_data[8*k +: 8];
            end
            wr_ptr_d = wr_ptr_q + PW'(nwr);
         end
         if (rd_fire) rd_ptr_d = rd_ptr_q + PW'(nrd);
         // Both sides judged against the pre-cycle count; no same-cycle bypass.
         count_d = count_q + (wr_fire ? CW'(nwr) : CW'(0)) - (rd_fire ? CW'(nrd) : CW'(0));
         err_d   = err_q | (i_wr_en && i_wr_size == 2'd3) | (i_rd_en && i_rd_size == 2'd3);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         err_q    <= err_d;
      end
   end

   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end

   assign o_left_bytes = count_q;
   assign o_empty      = (count_q == '0);
   assign o_full       = (count_q == CW'(DEPTH));
   assign o_err        = err_q;

`ifdef DMA_FIFO_THRESH_EN
   logic [CW-1:0] thresh;
   assign thresh    = CW'((int'(i_fth) + 1) * (DEPTH / 4));
   assign o_fth_hit = (count_q >= thresh);
`endif
endmodule

// File: tb/tb_dma_stream_fifo.sv
// Scoreboard bench for dma_stream_fifo: directed scenarios then randomized traffic,
// checked against a byte-queue reference model.
module tb_dma_stream_fifo;
   localparam int DEPTH = 32;

   logic        clk = 1'b0;
   logic        i_reset, i_clear, i_wr_en, i_rd_en;
   logic [1:0]  i_wr_size, i_rd_size, i_fth;
   logic [31:0] i_wr_data, o_rd_data;
   logic        o_wr_ready, o_rd_valid, o_empty, o_full, o_err;
   logic [5:0]  o_left_bytes;
`ifdef DMA_FIFO_THRESH_EN
   logic        o_fth_hit;
`endif

   always #5 clk = ~clk;

   dma_stream_fifo #(.fifo_size(5)) dut (
      .i_clk(clk), .i_reset(i_reset), .i_clear(i_clear),
      .i_wr_en(i_wr_en), .i_wr_size(i_wr_size), .i_wr_data(i_wr_data), .o_wr_ready(o_wr_ready),
      .i_rd_en(i_rd_en), .i_rd_size(i_rd_size), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
      .o_left_bytes(o_left_bytes), .o_empty(o_empty), .o_full(o_full),
`ifdef DMA_FIFO_THRESH_EN
      .i_fth(i_fth), .o_fth_hit(o_fth_hit),
`endif
      .o_err(o_err)
   );

   typedef struct {
      logic [31:0] rd_data;
      logic [5:0]  left;
      logic        rd_valid, wr_ready, empty, full, err, fth_hit;
   } exp_t;

   exp_t        exp_q[$];
   byte unsigned mq[$];
   bit          m_err = 1'b0;
   int          n_pass = 0, n_chk = 0;

   function automatic int nb(input logic [1:0] s);
      return (s == 2'd3) ? 0 : (1 << s);
   endfunction

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
   endfunction

   // Drive one cycle, record what the outputs must be, then advance the model past the edge.
   task automatic step(input bit rst, input bit clr, input bit we, input logic [1:0] ws,
                       input logic [31:0] wd, input bit re, input logic [1:0] rs,
                       input logic [1:0] fth);
      exp_t e;
      int n, nw, nr;
      bit wf, rf;
      @(posedge clk); #1;
      i_reset = rst; i_clear = clr; i_wr_en = we; i_wr_size = ws; i_wr_data = wd;
      i_rd_en = re; i_rd_size = rs; i_fth = fth;
      n  = mq.size();
      nw = nb(ws);
      nr = nb(rs);
      e.left     = 6'(n);
      e.empty    = (n == 0);
      e.full     = (n == DEPTH);
      e.err      = m_err;
      e.wr_ready = (nw != 0) && (DEPTH - n >= nw);
      e.rd_valid = (nr != 0) && (n >= nr);
      e.rd_data  = 32'h0;
      if (e.rd_valid) for (int k = 0; k < nr; k++) e.rd_data[8*k +: 8] = mq[k];
      e.fth_hit  = (n >= (int'(fth) + 1) * DEPTH / 4);
      exp_q.push_back(e);
      wf = we && e.wr_ready;
      rf = re && e.rd_valid;
      if (rst || clr) begin
         mq.delete();
         m_err = 1'b0;
      end else begin
         if (rf) repeat (nr) void'(mq.pop_front());
         if (wf) for (int k = 0; k < nw; k++) mq.push_back(wd[8*k +: 8]);
         if ((we && ws == 2'd3) || (re && rs == 2'd3)) m_err = 1'b1;
      end
   endtask

   task automatic idle();                                step(0, 0, 0, 2'd0, 32'h0, 0, 2'd0, 2'd0); endtask
   task automatic push(input logic [1:0] s, input logic [31:0] d); step(0, 0, 1, s, d, 0, 2'd0, 2'd0); endtask
   task automatic pop(input logic [1:0] s);               step(0, 0, 0, 2'd0, 32'h0, 1, s, 2'd0); endtask
   task automatic clear();                               step(0, 1, 0, 2'd0, 32'h0, 0, 2'd0, 2'd0); endtask

   // Monitor: compares every presented output against the oldest expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("left_bytes", 32'(o_left_bytes), 32'(e.left));
            chk("empty",      32'(o_empty),      32'(e.empty));
            chk("full",       32'(o_full),       32'(e.full));
            chk("err",        32'(o_err),        32'(e.err));
            chk("wr_ready",   32'(o_wr_ready),   32'(e.wr_ready));
            chk("rd_valid",   32'(o_rd_valid),   32'(e.rd_valid));
            chk("rd_data",    o_rd_data,         e.rd_data);
`ifdef DMA_FIFO_THRESH_EN
            chk("fth_hit",    32'(o_fth_hit),    32'(e.fth_hit));
`endif
         end
      end
   end

   initial begin
      i_reset = 1'b1; i_clear = 1'b0; i_wr_en = 1'b0; i_rd_en = 1'b0;
      i_wr_size = 2'd0; i_rd_size = 2'd0; i_wr_data = 32'h0; i_fth = 2'd0;
      repeat (2) @(posedge clk);

      // Reset state, then word push and byte-wise drain.
      idle();
      push(2'd2, 32'h4433_2211);
      for (int i = 0; i < 4; i++) pop(2'd0);
      idle();

      // Fill to full; ninth push must stall.
      for (int i = 0; i < 9; i++) push(2'd2, 32'hA000_0000 + i);
      idle();
      for (int i = 0; i < 8; i++) pop(2'd2);

      // Walk pointers to 30, then a word that straddles the wrap.
      clear();
      for (int i = 0; i < 30; i++) step(0, 0, 1, 2'd0, 32'(i), 1, 2'd0, 2'd0);
      pop(2'd0);
      push(2'd2, 32'hDDCC_BBAA);
      pop(2'd2);
      idle();

      // count=3: word pop stalls, half pop fires.
      for (int i = 0; i < 3; i++) push(2'd0, 32'h50 + i);
      pop(2'd2);
      pop(2'd1);
      idle();

      // count=10, concurrent word push + half pop, then clear with a push.
      clear();
      push(2'd2, 32'h0403_0201);
      push(2'd2, 32'h0807_0605);
      push(2'd1, 32'h0000_0A09);
      step(0, 0, 1, 2'd2, 32'h0E0D_0C0B, 1, 2'd1, 2'd0);
      idle();
      step(0, 1, 1, 2'd2, 32'h1111_1111, 0, 2'd0, 2'd0);
      idle();

      // Illegal sizes set a sticky error that only clear removes.
      push(2'd3, 32'hFFFF_FFFF);
      idle();
      pop(2'd3);
      push(2'd0, 32'h77);
      clear();
      idle();

      // Threshold crossing at 16 bytes with i_fth=1.
      for (int i = 0; i < 15; i++) step(0, 0, 1, 2'd0, 32'(i), 0, 2'd0, 2'd1);
      step(0, 0, 1, 2'd0, 32'h99, 0, 2'd0, 2'd1);
      step(0, 0, 0, 2'd0, 32'h0, 0, 2'd0, 2'd1);
      step(1, 0, 0, 2'd0, 32'h0, 0, 2'd0, 2'd1);
      idle();

      // Randomized traffic, alternating fill-heavy and drain-heavy phases.
      for (int i = 0; i < 3000; i++) begin
         bit fillp, we, re, rst, clr;
         logic [1:0] ws, rs;
         fillp = ((i / 64) % 2) == 0;
         we  = ($urandom_range(0, 99) < (fillp ? 80 : 30));
         re  = ($urandom_range(0, 99) < (fillp ? 30 : 80));
         ws  = ($urandom_range(0, 31) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         rs  = ($urandom_range(0, 31) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         rst = ($urandom_range(0, 299) == 0);
         clr = ($urandom_range(0, 149) == 0);
         step(rst, clr, we, ws, $urandom, re, rs, 2'($urandom_range(0, 3)));
      end
      idle();

      repeat (3) @(negedge clk);
      n_chk++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending want 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
